// File: rtl/key_expand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_expand_sequencer
//  Description : Iterative AES key-schedule engine. Produces one 32-bit
//                schedule word per cycle (single SubWord + XOR datapath),
//                stores the schedule and serves 128-bit round keys through
//                a registered read port while advertising how many round
//                keys are already complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_expand_sequencer #(
    parameter int KEY_BITS   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [3:0]          rounds_avail,
    input  logic                rk_rd_en,
    input  logic [3:0]          rk_rd_idx,
    output logic [127:0]        rk_rd_data,
    output logic                rk_rd_valid
);

    localparam int NK = KEY_BITS / 32;
    localparam int NW = 4 * (NUM_ROUNDS + 1);
    localparam int IW = $clog2(NW + 1);
    localparam int AW = $clog2(NW);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (maps 0 to 0), then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [2:0]    j_q, j_d;              // i mod NK, kept as its own counter
    logic [7:0]    rcon_q, rcon_d;
    logic [31:0]   win_q [NK];            // win_q[NK-1] = w[i-1], win_q[0] = w[i-NK]
    logic [31:0]   win_d [NK];
    logic [3:0]    rounds_q, rounds_d;
    logic [127:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   store_q [NW];

    logic          w_accept;
    logic [31:0]   w_temp;
    logic [31:0]   w_new_word;
    logic [IW:0]   w_ip1;
    logic [AW-1:0] w_base;
    logic          w_rd_ok;

    assign w_accept = key_valid & key_ready & ~abort;
    assign w_ip1    = {1'b0, i_q} + {{IW{1'b0}}, 1'b1};
    assign w_base   = AW'({rk_rd_idx, 2'b00});
    assign w_rd_ok  = rk_rd_en && (rk_rd_idx < rounds_q) && (rk_rd_idx <= 4'(NUM_ROUNDS));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort outranks a simultaneous key accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort)          state_d = S_IDLE;
                else if (key_valid) state_d = S_EXPAND;
            end
            S_EXPAND: begin
                if (abort)                      state_d = S_IDLE;
                else if (i_q == IW'(NW - 1))    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        key_ready = (state_q != S_EXPAND);
        busy      = (state_q == S_EXPAND);
        done      = (state_q == S_DONE);
    end

    // One schedule word: temp from w[i-1], combined with w[i-NK]
    always_comb begin
        w_temp = win_q[NK-1];
        if (j_q == 3'd0)
            w_temp = subword({w_temp[23:0], w_temp[31:24]}) ^ {rcon_q, 24'h000000};
        else if (NK == 8 && j_q == 3'd4)
            w_temp = subword(w_temp);
        w_new_word = win_q[0] ^ w_temp;
    end

    // Expansion control and sliding-window next state
    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        rcon_d   = rcon_q;
        rounds_d = rounds_q;
        for (int k = 0; k < NK; k++) win_d[k] = win_q[k];
        if (abort) begin
            rounds_d = 4'd0;
        end else if (w_accept) begin
            i_d      = IW'(NK);
            j_d      = 3'd0;
            rcon_d   = 8'h01;
            rounds_d = 4'(NK / 4);
            for (int k = 0; k < NK; k++) win_d[k] = key_in[KEY_BITS-1-32*k -: 32];
        end else if (state_q == S_EXPAND) begin
            i_d      = i_q + IW'(1);
            j_d      = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0)
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            rounds_d = 4'(w_ip1 >> 2);
            for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
            win_d[NK-1] = w_new_word;
        end
    end

    // Read port: capture a round key only when it is already complete
    always_comb begin
        rd_valid_d = w_rd_ok;
        rd_data_d  = rd_data_q;
        if (w_rd_ok)
            rd_data_d = {store_q[w_base], store_q[w_base + AW'(1)],
                         store_q[w_base + AW'(2)], store_q[w_base + AW'(3)]};
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_q        <= '0;
            j_q        <= 3'd0;
            rcon_q     <= 8'h01;
            rounds_q   <= 4'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int k = 0; k < NK; k++) win_q[k] <= 32'h0;
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            rcon_q     <= rcon_d;
            rounds_q   <= rounds_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            for (int k = 0; k < NK; k++) win_q[k] <= win_d[k];
        end
    end

    // Round-key store; contents are meaningless until counted in rounds_avail
    always_ff @(posedge clock) begin
        if (w_accept) begin
            for (int k = 0; k < NK; k++) store_q[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end else if (state_q == S_EXPAND && !abort) begin
            store_q[i_q[AW-1:0]] <= w_new_word;
        end
    end

    assign rounds_avail = rounds_q;
    assign rk_rd_data   = rd_data_q;
    assign rk_rd_valid  = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_key_expand_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_key_expand_sequencer
//  Description : Self-checking bench for key_expand_sequencer (AES-128 and
//                AES-256 instances) with a reference key-schedule model and
//                a read-response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_expand_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic [127:0] a_key;  logic a_kv, a_kr, a_abort, a_busy, a_done, a_en, a_rv;
    logic [3:0]   a_ra, a_idx;  logic [127:0] a_rd;
    logic [255:0] b_key;  logic b_kv, b_kr, b_abort, b_busy, b_done, b_en, b_rv;
    logic [3:0]   b_ra, b_idx;  logic [127:0] b_rd;

    key_expand_sequencer #(.KEY_BITS(128), .NUM_ROUNDS(10)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .key_in(a_key), .key_valid(a_kv),
        .key_ready(a_kr), .abort(a_abort), .busy(a_busy), .done(a_done),
        .rounds_avail(a_ra), .rk_rd_en(a_en), .rk_rd_idx(a_idx),
        .rk_rd_data(a_rd), .rk_rd_valid(a_rv));

    key_expand_sequencer #(.KEY_BITS(256), .NUM_ROUNDS(14)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .key_in(b_key), .key_valid(b_kv),
        .key_ready(b_kr), .abort(b_abort), .busy(b_busy), .done(b_done),
        .rounds_avail(b_ra), .rk_rd_en(b_en), .rk_rd_idx(b_idx),
        .rk_rd_data(b_rd), .rk_rd_valid(b_rv));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference key schedule ----------------
    logic [31:0] mw [0:59];

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00; x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv, s, c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++)
            if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int b = 0; b < 8; b++)
            s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
        return s;
    endfunction

    function automatic logic [31:0] tb_sub(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic build_sched(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        int nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int k = 0; k < nk; k++) mw[k] = key[255-32*k -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = tb_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = tb_sub(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // ---------------- read scoreboard ----------------
    typedef struct { logic v; logic [127:0] d; } exp_t;
    exp_t         sb[$];
    logic [127:0] last_d [2];
    logic [127:0] got_d;

    task automatic rd(input int sel, input int idx, input logic ev, input string tag);
        exp_t e;
        logic v;
        logic [127:0] d;
        @(negedge clock);
        e.v = ev;
        if (ev) e.d = {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
        else    e.d = last_d[sel];
        sb.push_back(e);
        if (sel == 0) begin a_en = 1'b1; a_idx = 4'(idx); end
        else          begin b_en = 1'b1; b_idx = 4'(idx); end
        @(posedge clock); #1;
        if (sel == 0) begin a_en = 1'b0; v = a_rv; d = a_rd; end
        else          begin b_en = 1'b0; v = b_rv; d = b_rd; end
        e = sb.pop_front();
        check_val({tag, "_valid"}, 128'(v), 128'(e.v));
        check_val({tag, "_data"}, d, e.d);
        if (e.v) last_d[sel] = e.d;
        got_d = d;
    endtask

    task automatic read_all(input int sel, input int nr, input string tag);
        for (int r = 0; r <= nr; r++) rd(sel, r, 1'b1, $sformatf("%s_rk%0d", tag, r));
    endtask

    task automatic accept(input int sel, input logic [255:0] key, input string tag);
        @(negedge clock);
        if (sel == 0) begin
            check_val({tag, "_kr_pre"}, 128'(a_kr), 128'd1);
            a_key = key[255:128]; a_kv = 1'b1;
        end else begin
            check_val({tag, "_kr_pre"}, 128'(b_kr), 128'd1);
            b_key = key; b_kv = 1'b1;
        end
        @(posedge clock); #1;
        if (sel == 0) begin
            a_kv = 1'b0;
            check_val({tag, "_kr"},   128'(a_kr),   128'd0);
            check_val({tag, "_busy"}, 128'(a_busy), 128'd1);
            check_val({tag, "_done"}, 128'(a_done), 128'd0);
            check_val({tag, "_ra"},   128'(a_ra),   128'd1);
        end else begin
            b_kv = 1'b0;
            check_val({tag, "_kr"},   128'(b_kr),   128'd0);
            check_val({tag, "_busy"}, 128'(b_busy), 128'd1);
            check_val({tag, "_done"}, 128'(b_done), 128'd0);
            check_val({tag, "_ra"},   128'(b_ra),   128'd2);
        end
    endtask

    task automatic wait_done(input int sel, input int start, input int exp_cyc, input string tag);
        int cyc;
        cyc = start;
        while (!(sel == 0 ? a_done : b_done) && cyc < 300) begin
            @(posedge clock); #1;
            cyc++;
        end
        check_val({tag, "_latency"}, 128'(cyc), 128'(exp_cyc));
        if (sel == 0) begin
            check_val({tag, "_ra_final"}, 128'(a_ra),   128'd11);
            check_val({tag, "_busy_end"}, 128'(a_busy), 128'd0);
            check_val({tag, "_kr_end"},   128'(a_kr),   128'd1);
        end else begin
            check_val({tag, "_ra_final"}, 128'(b_ra),   128'd15);
            check_val({tag, "_busy_end"}, 128'(b_busy), 128'd0);
            check_val({tag, "_kr_end"},   128'(b_kr),   128'd1);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check_val({tag, "_kr"},   128'(a_kr),   128'd1);
        check_val({tag, "_busy"}, 128'(a_busy), 128'd0);
        check_val({tag, "_done"}, 128'(a_done), 128'd0);
        check_val({tag, "_ra"},   128'(a_ra),   128'd0);
        check_val({tag, "_rv"},   128'(a_rv),   128'd0);
        check_val({tag, "_rd"},   a_rd,         128'd0);
    endtask

    localparam logic [255:0] KEY_A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_B = {128'h00112233445566778899aabbccddeeff, 128'h0};
    localparam logic [255:0] KEY_C = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_D = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        a_key = '0; a_kv = 0; a_abort = 0; a_en = 0; a_idx = '0;
        b_key = '0; b_kv = 0; b_abort = 0; b_en = 0; b_idx = '0;
        last_d[0] = '0; last_d[1] = '0; got_d = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_a("rst_a");
        check_val("rst_b_kr",   128'(b_kr),   128'd1);
        check_val("rst_b_busy", 128'(b_busy), 128'd0);
        check_val("rst_b_ra",   128'(b_ra),   128'd0);
        check_val("rst_b_rd",   b_rd,         128'd0);
        @(negedge clock) reset_n = 1'b1;

        // AES-128 with early consumption of round key 2
        build_sched(KEY_A, 4);
        accept(0, KEY_A, "t1");
        repeat (7) @(posedge clock);
        #1 check_val("t1_ra_before3", 128'(a_ra), 128'd2);
        @(posedge clock);
        #1 check_val("t1_ra_is3", 128'(a_ra), 128'd3);
        rd(0, 2, 1'b1, "t1_early_rk2");
        check_val("t1_kat_rk2", got_d, 128'hf2c295f27a96b9435935807a7359f67f);
        wait_done(0, 9, 40, "t1");
        rd(0, 1, 1'b1, "t1_rk1");
        check_val("t1_kat_rk1", got_d, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(0, 10, 1'b1, "t1_rk10");
        check_val("t1_kat_rk10", got_d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(0, 11, 1'b0, "t1_oob11");
        rd(0, 15, 1'b0, "t1_oob15");

        // Rekey in DONE, early read of an incomplete round, then abort with key_valid
        accept(0, KEY_A, "t2");
        repeat (7) @(posedge clock);
        @(posedge clock);
        #1 check_val("t2_ra_is3", 128'(a_ra), 128'd3);
        rd(0, 3, 1'b0, "t2_early_rk3");
        repeat (10) @(posedge clock);
        @(negedge clock);
        a_abort = 1'b1; a_kv = 1'b1; a_key = KEY_B[255:128];
        @(posedge clock); #1;
        a_abort = 1'b0;
        check_val("t2_abort_busy", 128'(a_busy), 128'd0);
        check_val("t2_abort_done", 128'(a_done), 128'd0);
        check_val("t2_abort_ra",   128'(a_ra),   128'd0);
        check_val("t2_abort_kr",   128'(a_kr),   128'd1);
        @(posedge clock); #1;
        a_kv = 1'b0;
        check_val("t2_newkey_busy", 128'(a_busy), 128'd1);
        build_sched(KEY_B, 4);
        wait_done(0, 0, 40, "t2");
        read_all(0, 10, "t2");

        // Asynchronous reset mid-expansion
        build_sched(KEY_A, 4);
        accept(0, KEY_A, "t3");
        rd(0, 0, 1'b1, "t3_rk0");
        repeat (13) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_reset_a("t3_async");
        last_d[0] = '0;
        @(negedge clock) reset_n = 1'b1;
        build_sched(KEY_C, 4);
        accept(0, KEY_C, "t3b");
        wait_done(0, 0, 40, "t3b");
        read_all(0, 10, "t3b");

        // Rekey while DONE: done drops and rounds_avail restarts at 1
        build_sched(KEY_A, 4);
        accept(0, KEY_A, "t4");
        wait_done(0, 0, 40, "t4");
        read_all(0, 10, "t4");

        // AES-256 instance
        build_sched(KEY_D, 8);
        accept(1, KEY_D, "t5");
        wait_done(1, 0, 52, "t5");
        read_all(1, 14, "t5");
        rd(1, 14, 1'b1, "t5_rk14");
        check_val("t5_kat_rk14", got_d, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        rd(1, 15, 1'b0, "t5_oob15");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
